// File: rtl/axi_lite_master_pkg.sv
// Shared types and fixed AXI field encodings for the AXI4-Lite initiator port.
`timescale 1ns/1ps
package axi_lite_master_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_B = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4
  } state_e;

  localparam logic [2:0] SIZE_64    = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_lite_master_port_if.sv
// AXI channel bundle between the initiator port and a memory-mapped slave.
`timescale 1ns/1ps
interface axi_lite_master_port_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite initiator: turns req/gnt memory requests into
// one single-beat AXI transaction each and returns a one-cycle response pulse.
`timescale 1ns/1ps
module axi_lite_master_port
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned ID_VALUE       = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [BE_W-1:0]           be_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  axi_lite_master_port_if.Master    master
);

`ifndef SYNTHESIS
  if (AXI_DATA_WIDTH != 64) begin : gen_dw_check
    $error("axi_lite_master_port supports AXI_DATA_WIDTH == 64 only");
  end
`endif

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [BE_W-1:0]           be_q, be_d;
  logic                      we_q, we_d;
  logic                      rvalid_q, rvalid_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      err_q, err_d;

  // Valids/readies come from state flops only, never from AXI inputs.
  logic aw_valid_c, w_valid_c, ar_valid_c, b_ready_c, r_ready_c;
  logic aw_hs_c, w_hs_c, ar_hs_c, b_hs_c, r_hs_c;

  assign aw_valid_c = (state_q == WRITE) && !aw_done_q;
  assign w_valid_c  = (state_q == WRITE) && !w_done_q;
  assign ar_valid_c = (state_q == READ);
  assign b_ready_c  = (state_q == WAIT_B);
  assign r_ready_c  = (state_q == WAIT_R);

  assign aw_hs_c = aw_valid_c && master.aw_ready;
  assign w_hs_c  = w_valid_c  && master.w_ready;
  assign ar_hs_c = ar_valid_c && master.ar_ready;
  assign b_hs_c  = b_ready_c  && master.b_valid;
  assign r_hs_c  = r_ready_c  && master.r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          be_d      = be_i;
          we_d      = we_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        // AW and W finish independently, possibly in the same cycle.
        aw_done_d = aw_done_q | aw_hs_c;
        w_done_d  = w_done_q  | w_hs_c;
        if (aw_done_d && w_done_d) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (b_hs_c) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = master.b_resp[1];
        end
      end
      READ: begin
        if (ar_hs_c) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (r_hs_c) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = master.r_data;
          err_d    = master.r_resp[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign master.aw_id     = AXI_ID_WIDTH'(ID_VALUE);
  assign master.aw_addr   = addr_q;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = SIZE_64;
  assign master.aw_burst  = BURST_INCR;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_atop   = 6'd0;
  assign master.aw_user   = AXI_USER_WIDTH'(0);
  assign master.aw_valid  = aw_valid_c;

  assign master.w_data  = AXI_DATA_WIDTH'(wdata_q);
  assign master.w_strb  = be_q;
  assign master.w_last  = 1'b1;
  assign master.w_user  = AXI_USER_WIDTH'(0);
  assign master.w_valid = w_valid_c;

  assign master.b_ready = b_ready_c;

  assign master.ar_id     = AXI_ID_WIDTH'(ID_VALUE);
  assign master.ar_addr   = addr_q;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = SIZE_64;
  assign master.ar_burst  = BURST_INCR;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = AXI_USER_WIDTH'(0);
  assign master.ar_valid  = ar_valid_c;

  assign master.r_ready = r_ready_c;

  // Response IDs and user bits are intentionally ignored.
  logic unused_c;
  assign unused_c = ^{we_q, master.b_id, master.b_user, master.b_resp[0],
                      master.r_id, master.r_user, master.r_last, master.r_resp[0]};

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Cycle-level directed bench for axi_lite_master_port with a hand-driven AXI slave.
`timescale 1ns/1ps
module tb_axi_lite_master_port;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam int   NVEC = 26;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [63:0] rdata_o;

  int n_vec = 0;
  int n_err = 0;
  int n_rv  = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_master_port_if #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)
  ) bus ();

  axi_lite_master_port #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
    .AXI_USER_WIDTH(1), .ID_VALUE(0)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .master   (bus)
  );

  typedef struct {
    logic        req, we;
    logic [63:0] addr, wdata;
    logic [7:0]  be;
    logic        bv;
    logic [1:0]  bresp;
    logic        rv;
    logic [63:0] rd;
    logic [1:0]  rresp;
    logic        e_gnt, e_awv, e_wv, e_brdy, e_arv, e_rrdy, e_rvalid;
    logic [63:0] e_rdata;
    logic        e_err;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_be;
  } vec_t;

  vec_t tbl [NVEC];

  // {aw_valid, w_valid, b_ready, ar_valid, r_ready, rvalid_o}
  function automatic logic [5:0] ctl();
    return {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rvalid_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic slv(input logic awr, input logic wr, input logic arr, input logic bv,
                     input logic [1:0] br, input logic rv, input logic [63:0] rd,
                     input logic [1:0] rr);
    bus.aw_ready = awr;
    bus.w_ready  = wr;
    bus.ar_ready = arr;
    bus.b_valid  = bv;
    bus.b_resp   = br;
    bus.r_valid  = rv;
    bus.r_data   = rd;
    bus.r_resp   = rr;
  endtask

  task automatic drv(input logic req, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] be);
    req_i = req; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] act8, exp8;
    logic       ok;

    rst_ni = 1'b0;
    drv(N, N, 64'h0, 64'h0, 8'h0);
    slv(N, N, N, N, 2'b00, N, 64'h0, 2'b00);
    bus.b_id = 10'h3FF; bus.b_user = 1'b0;   // deliberately mismatched IDs
    bus.r_id = 10'h155; bus.r_user = 1'b0; bus.r_last = 1'b1;

    // req we addr wdata be | bv bresp rv rd rresp | gnt awv wv brdy arv rrdy rvalid rdata err | addr wdata be
    tbl[0]  = '{Y,Y,64'h400,64'h1234,8'hFF, N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,N,64'h0,N, 64'h0,64'h0,8'h0};
    tbl[1]  = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,Y,Y,N,N,N,N,64'h0,N, 64'h400,64'h1234,8'hFF};
    tbl[2]  = '{N,N,64'h0,64'h0,8'h0,       Y,2'b00,N,64'h0,2'b00, N,N,N,Y,N,N,N,64'h0,N, 64'h0,64'h0,8'h0};
    tbl[3]  = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,N,N,Y,64'h0,N, 64'h0,64'h0,8'h0};
    tbl[4]  = '{Y,N,64'hC00,64'h0,8'h0,     N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,N,64'h0,N, 64'h0,64'h0,8'h0};
    tbl[5]  = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,Y,N,N,64'h0,N, 64'hC00,64'h0,8'h0};
    tbl[6]  = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,Y,64'hDEAD_BEEF,2'b00, N,N,N,N,N,Y,N,64'h0,N, 64'h0,64'h0,8'h0};
    tbl[7]  = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,N,N,Y,64'hDEAD_BEEF,N, 64'h0,64'h0,8'h0};
    tbl[8]  = '{Y,Y,64'h408,64'hAAAA,8'h0F, N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,N,64'hDEAD_BEEF,N, 64'h0,64'h0,8'h0};
    tbl[9]  = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,Y,Y,N,N,N,N,64'hDEAD_BEEF,N, 64'h408,64'hAAAA,8'h0F};
    tbl[10] = '{N,N,64'h0,64'h0,8'h0,       Y,2'b10,N,64'h0,2'b00, N,N,N,Y,N,N,N,64'hDEAD_BEEF,N, 64'h0,64'h0,8'h0};
    tbl[11] = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,N,N,Y,64'hDEAD_BEEF,Y, 64'h0,64'h0,8'h0};
    tbl[12] = '{Y,N,64'h10,64'h0,8'h0,      N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,N,64'hDEAD_BEEF,Y, 64'h0,64'h0,8'h0};
    tbl[13] = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,Y,N,N,64'hDEAD_BEEF,Y, 64'h10,64'h0,8'h0};
    tbl[14] = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,Y,64'h5555,2'b00, N,N,N,N,N,Y,N,64'hDEAD_BEEF,Y, 64'h0,64'h0,8'h0};
    tbl[15] = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,N,N,Y,64'h5555,N, 64'h0,64'h0,8'h0};
    tbl[16] = '{Y,Y,64'h20,64'h1,8'hFF,     N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,N,64'h5555,N, 64'h0,64'h0,8'h0};
    tbl[17] = '{Y,N,64'h28,64'h0,8'h0,      N,2'b00,N,64'h0,2'b00, N,Y,Y,N,N,N,N,64'h5555,N, 64'h20,64'h1,8'hFF};
    tbl[18] = '{Y,N,64'h28,64'h0,8'h0,      Y,2'b00,N,64'h0,2'b00, N,N,N,Y,N,N,N,64'h5555,N, 64'h0,64'h0,8'h0};
    tbl[19] = '{Y,N,64'h28,64'h0,8'h0,      N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,Y,64'h5555,N, 64'h0,64'h0,8'h0};
    tbl[20] = '{Y,Y,64'h30,64'h2,8'h3C,     N,2'b00,N,64'h0,2'b00, N,N,N,N,Y,N,N,64'h5555,N, 64'h28,64'h0,8'h0};
    tbl[21] = '{Y,Y,64'h30,64'h2,8'h3C,     N,2'b00,Y,64'h77,2'b00, N,N,N,N,N,Y,N,64'h5555,N, 64'h0,64'h0,8'h0};
    tbl[22] = '{Y,Y,64'h30,64'h2,8'h3C,     N,2'b00,N,64'h0,2'b00, Y,N,N,N,N,N,Y,64'h77,N, 64'h0,64'h0,8'h0};
    tbl[23] = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,Y,Y,N,N,N,N,64'h77,N, 64'h30,64'h2,8'h3C};
    tbl[24] = '{N,N,64'h0,64'h0,8'h0,       Y,2'b00,N,64'h0,2'b00, N,N,N,Y,N,N,N,64'h77,N, 64'h0,64'h0,8'h0};
    tbl[25] = '{N,N,64'h0,64'h0,8'h0,       N,2'b00,N,64'h0,2'b00, N,N,N,N,N,N,Y,64'h77,N, 64'h0,64'h0,8'h0};

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_ctl", 64'({gnt_o, ctl(), err_o}), 64'h0);
    chk("reset_rdata", rdata_o, 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Always-ready slave: write, read, error write, read, back-to-back
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      drv(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      slv(Y, Y, Y, tbl[i].bv, tbl[i].bresp, tbl[i].rv, tbl[i].rd, tbl[i].rresp);
      #1;
      act8 = {gnt_o, bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rvalid_o, err_o};
      exp8 = {tbl[i].e_gnt, tbl[i].e_awv, tbl[i].e_wv, tbl[i].e_brdy, tbl[i].e_arv,
              tbl[i].e_rrdy, tbl[i].e_rvalid, tbl[i].e_err};
      ok = (act8 === exp8) && (rdata_o === tbl[i].e_rdata);
      if (tbl[i].e_awv && (bus.aw_addr !== tbl[i].e_addr)) ok = 1'b0;
      if (tbl[i].e_arv && (bus.ar_addr !== tbl[i].e_addr)) ok = 1'b0;
      if (tbl[i].e_wv && ((bus.w_data !== tbl[i].e_wdata) || (bus.w_strb !== tbl[i].e_be) ||
                          (bus.w_last !== 1'b1))) ok = 1'b0;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: ctl %b rdata %h aw %h ar %h w %h/%h, want ctl %b rdata %h addr %h w %h/%h",
                 i, act8, rdata_o, bus.aw_addr, bus.ar_addr, bus.w_data, bus.w_strb,
                 exp8, tbl[i].e_rdata, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_be);
      end
    end

    // Skewed write: W ready three cycles before AW ready
    @(negedge clk_i);
    drv(Y, Y, 64'h500, 64'hBEEF, 8'hFF);
    slv(N, N, N, N, 2'b00, N, 64'h0, 2'b00);
    #1 chk("skew_gnt", 64'(gnt_o), 64'h1);
    @(negedge clk_i);
    drv(N, N, 64'h0, 64'h0, 8'h0);
    bus.w_ready = 1'b1;
    #1 chk("skew_s1", 64'(ctl()), 64'(6'b110000));
    chk("aw_fixed", 64'({bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_lock,
                         bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region, bus.aw_atop,
                         bus.aw_user}), 64'({10'd0, 8'd0, 3'd3, 2'b01, 23'd0}));
    chk("w_fixed", 64'({bus.w_last, bus.w_user}), 64'(2'b10));
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk_i);
      #1 chk($sformatf("skew_s%0d", c), 64'(ctl()), 64'(6'b100000));
      chk($sformatf("skew_addr_s%0d", c), bus.aw_addr, 64'h500);
    end
    @(negedge clk_i);
    bus.aw_ready = 1'b1;
    #1 chk("skew_s4", 64'(ctl()), 64'(6'b100000));
    @(negedge clk_i);
    bus.b_valid = 1'b1;
    #1 chk("skew_s5", 64'(ctl()), 64'(6'b001000));
    n_rv = 0;
    for (int c = 6; c <= 8; c++) begin
      @(negedge clk_i);
      bus.b_valid = 1'b0;
      #1 n_rv += int'(rvalid_o);
    end
    chk("skew_rvalid_count", 64'(n_rv), 64'h1);

    // Reset while AW/W are pending: valids must drop asynchronously
    @(negedge clk_i);
    drv(Y, Y, 64'h600, 64'h1, 8'hFF);
    slv(N, N, N, N, 2'b00, N, 64'h0, 2'b00);
    #1;
    @(negedge clk_i);
    drv(N, N, 64'h0, 64'h0, 8'h0);
    #1 chk("rstw_before", 64'(ctl()), 64'(6'b110000));
    #1 rst_ni = 1'b0;
    #1 chk("rstw_after", 64'(ctl()), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset while waiting in WAIT_B: no response, clean restart
    @(negedge clk_i);
    drv(Y, Y, 64'h700, 64'h9, 8'hFF);
    slv(Y, Y, Y, N, 2'b00, N, 64'h0, 2'b00);
    #1;
    @(negedge clk_i);
    drv(N, N, 64'h0, 64'h0, 8'h0);
    #1;
    @(negedge clk_i);
    #1 chk("rstb_before", 64'(ctl()), 64'(6'b001000));
    #1 rst_ni = 1'b0;
    #1 chk("rstb_after", 64'({ctl(), err_o}), 64'h0);
    chk("rstb_rdata", rdata_o, 64'h0);
    @(negedge clk_i);
    bus.b_valid = 1'b1;
    #1 chk("rstb_held", 64'(ctl()), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.b_valid = 1'b0;
    @(negedge clk_i);
    drv(Y, N, 64'h800, 64'h0, 8'h0);
    #1 chk("post_rst_gnt", 64'({gnt_o, rvalid_o}), 64'(2'b10));
    @(negedge clk_i);
    drv(N, N, 64'h0, 64'h0, 8'h0);
    #1 chk("post_rst_ar", bus.ar_addr, 64'h800);
    chk("ar_fixed", 64'({bus.ar_valid, bus.ar_id, bus.ar_len, bus.ar_size, bus.ar_burst,
                         bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos, bus.ar_region,
                         bus.ar_user}), 64'({1'b1, 10'd0, 8'd0, 3'd3, 2'b01, 17'd0}));
    @(negedge clk_i);
    slv(Y, Y, Y, N, 2'b00, Y, 64'hCAFE, 2'b00);
    #1 chk("post_rst_rready", 64'(ctl()), 64'(6'b000010));
    @(negedge clk_i);
    slv(Y, Y, Y, N, 2'b00, N, 64'h0, 2'b00);
    #1 chk("post_rst_resp", 64'({rvalid_o, err_o}), 64'(2'b10));
    chk("post_rst_rdata", rdata_o, 64'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
